spart_driver: RTL
=================

// Module: spart_driver
// PURPOSE
//  Bus-master controller for the SPART register interface (iocs/iorw/ioaddr/databus).
//  Programs the baud divisor from the board baud switches, polls rda/tbr, reads received bytes
//  and writes transmit bytes. Arbitrates the single SPART port between divisor reprogramming,
//  receive, loopback echo and a host transmit request. Sits beside the SPART in the top level.
// PARAMETERS
//  DIV_4800   16'd1301  divisor written for br_cfg=2'b00
//  DIV_9600   16'd650   divisor written for br_cfg=2'b01
//  DIV_19200  16'd324   divisor written for br_cfg=2'b10
//  DIV_38400  16'd162   divisor written for br_cfg=2'b11
//  ECHO_EN    1         1: every received byte is queued for retransmit (loopback echo)
// PORTS
//  clk       in     1   system clock
//  rst       in     1   asynchronous, active-high reset
//  br_cfg    in     2   baud select switches (asynchronous; synchronised internally)
//  rda       in     1   SPART receive data available
//  tbr       in     1   SPART transmit buffer ready
//  iocs      out    1   SPART chip select
//  iorw      out    1   1=read from SPART, 0=write to SPART
//  ioaddr    out    2   00=data, 10=divisor low, 11=divisor high
//  databus   inout  8   SPART data bus; driven only when iocs=1 and iorw=0, else 8'hzz
//  tx_req    in     1   host transmit request (level, held until tx_ack)
//  tx_data   in     8   host byte, stable while tx_req=1
//  tx_ack    out    1   one-cycle pulse: tx_data written to SPART
//  rx_valid  out    1   one-cycle pulse: rx_data holds a new received byte
//  rx_data   out    8   last received byte
//  cfg_done  out    1   high once the current divisor is fully programmed
// BEHAVIOUR
//  - Reset (async): state=CFG_LO, iocs=0, iorw=1, ioaddr=00, databus=Z, tx_ack=0, rx_valid=0,
//    rx_data=8'h00, cfg_done=0, echo buffer empty. iorw idles at 1 (SPART drives bus on reads).
//  - br_cfg passes a 2-flop synchroniser; cfg_sel latched when entering CFG_LO.
//  - States: CFG_LO, CFG_HI, IDLE, RX_RD, TX_WAIT, TX_WR, GAP.
//  - CFG_LO: iocs=1, iorw=0, ioaddr=10, databus=div[7:0]; -> CFG_HI.
//  - CFG_HI: iocs=1, iorw=0, ioaddr=11, databus=div[15:8]; -> IDLE; cfg_done=1 from next cycle.
//  - IDLE priority (highest first): (1) synced br_cfg != cfg_sel -> CFG_LO, cfg_done=0;
//    (2) rda=1 and echo buffer empty -> RX_RD; (3) echo buffer full -> TX_WAIT(echo);
//    (4) tx_req=1 -> TX_WAIT(host); else stay.
//  - RX_RD: iocs=1, iorw=1, ioaddr=00; databus sampled at end of cycle into rx_data;
//    rx_valid pulses the following cycle; if ECHO_EN, byte also loaded into echo buffer; -> GAP.
//  - TX_WAIT: bus idle; wait for tbr=1 (no timeout); reconfig is NOT taken mid-wait; -> TX_WR.
//  - TX_WR: iocs=1, iorw=0, ioaddr=00, databus=echo byte or tx_data; echo: buffer cleared;
//    host: tx_ack pulses the following cycle; -> GAP.
//  - GAP: one idle cycle so stale rda/tbr is not re-used; -> IDLE.
//  - Every SPART access is exactly one cycle with iocs=1; iocs=0 in IDLE, TX_WAIT, GAP.
//  - rda held while echo buffer full: byte stays in SPART (no drop); echo drains first.
//  - Host tx_req blocked while echo pending; tx_req dropped before TX_WR: write still issued
//    with tx_data sampled in TX_WR (host must hold per handshake; not checked).
//  - br_cfg change during CFG_LO/CFG_HI: finish sequence, IDLE re-detects, reprograms.
//  - Reset mid-operation: immediate abort, bus released, full reprogram after release.
//  - Latency: reset release -> cfg_done at cycle 3; rda seen in IDLE -> rx_valid 3 cycles
//    later; tbr=1 in TX_WAIT -> tx_ack 2 cycles later.
// TESTING
//  - Reset, br_cfg=01 -> writes 10:8'h8A then 11:8'h02 on cycles 1-2, cfg_done=1 cycle 3.
//  - br_cfg 01->11 while idle -> after sync, cfg_done=0, writes 8'hA2/8'h00, cfg_done=1.
//  - rda=1, SPART drives 8'h5A -> one RX_RD, rx_valid pulse with rx_data=5A, echo TX_WR of 5A
//    once tbr=1; databus never driven by driver while iorw=1.
//  - tx_req with tx_data=8'hC3, tbr=0 for 10 cycles -> no write; tbr=1 -> TX_WR C3, one tx_ack.
//  - Echo pending and rda=1 and tx_req=1 together -> order: echo write, then RX_RD, then host.
//  - Assert rst during TX_WAIT -> outputs return to reset values same cycle; reprogram follows.

Source files
------------

// File: rtl/spart_driver.sv
// -----------------------------------------------------------------------------
// spart_driver
// Bus master for the SPART register interface. Programs the baud divisor from
// the board switches, reads received bytes when rda is set, echoes them back
// (optional), and forwards host transmit requests. All SPART accesses are
// single-cycle strobes with iocs=1.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   br_cfg[1:0]       baud select switches (asynchronous, synchronised here)
//   rda, tbr          SPART receive-data-available / transmit-buffer-ready
//   iocs, iorw        SPART chip select, 1=read / 0=write
//   ioaddr[1:0]       00=data, 10=divisor low, 11=divisor high
//   databus[7:0]      SPART data bus, driven only during writes
//   tx_req, tx_data   host transmit request (level) and byte
//   tx_ack            one-cycle pulse when the host byte is written
//   rx_valid, rx_data one-cycle pulse with the newly received byte
//   cfg_done          high once the current divisor is programmed
//
// Timing: every bus output is registered from the current state, so the bus
// access for a state appears in the cycle after that state is entered.
// -----------------------------------------------------------------------------
module spart_driver #(
    parameter logic [15:0] DIV_4800  = 16'd1301,
    parameter logic [15:0] DIV_9600  = 16'd650,
    parameter logic [15:0] DIV_19200 = 16'd324,
    parameter logic [15:0] DIV_38400 = 16'd162,
    parameter bit          ECHO_EN   = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] br_cfg,
    input  logic       rda,
    input  logic       tbr,
    output logic       iocs,
    output logic       iorw,
    output logic [1:0] ioaddr,
    inout  wire  [7:0] databus,
    input  logic       tx_req,
    input  logic [7:0] tx_data,
    output logic       tx_ack,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       cfg_done
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 2;
    localparam int unsigned DIV_W  = 16;

    localparam logic [ADDR_W-1:0] ADDR_DATA   = 2'b00;
    localparam logic [ADDR_W-1:0] ADDR_DIV_LO = 2'b10;
    localparam logic [ADDR_W-1:0] ADDR_DIV_HI = 2'b11;

    typedef enum logic [2:0] {
        CFG_LO  = 3'd0,
        CFG_HI  = 3'd1,
        IDLE    = 3'd2,
        RX_RD   = 3'd3,
        TX_WAIT = 3'd4,
        TX_WR   = 3'd5,
        GAP     = 3'd6
    } state_t;

    // Divisor lookup for a baud selection.
    function automatic logic [DIV_W-1:0] div_for(input logic [1:0] sel);
        logic [DIV_W-1:0] d;
        case (sel)
            2'b00:   d = DIV_4800;
            2'b01:   d = DIV_9600;
            2'b10:   d = DIV_19200;
            default: d = DIV_38400;
        endcase
        return d;
    endfunction

    state_t            state_q,     state_d;
    logic [1:0]        cfg_sel_q,   cfg_sel_d;
    logic              cfg_done_q,  cfg_done_d;
    logic              iocs_q,      iocs_d;
    logic              iorw_q,      iorw_d;
    logic [ADDR_W-1:0] ioaddr_q,    ioaddr_d;
    logic [DATA_W-1:0] dout_q,      dout_d;
    logic              tx_ack_q,    tx_ack_d;
    logic              rx_valid_q,  rx_valid_d;
    logic [DATA_W-1:0] rx_data_q,   rx_data_d;
    logic              echo_full_q, echo_full_d;
    logic [DATA_W-1:0] echo_byte_q, echo_byte_d;
    logic              src_echo_q,  src_echo_d;

    logic [1:0]        br_meta_q;
    logic [1:0]        br_sync_q;
    logic              rd_done;

    // Switch synchroniser. Left without reset so it keeps tracking the
    // switches while rst is held; the first divisor written after reset
    // then already reflects the board setting.
    always_ff @(posedge clk) begin
        br_meta_q <= br_cfg;
        br_sync_q <= br_meta_q;
    end

    // A read strobe is on the bus this cycle; capture at its end.
    assign rd_done = iocs_q & iorw_q;

    // Next-state and registered-output decode.
    always_comb begin
        state_d     = state_q;
        cfg_sel_d   = cfg_sel_q;
        cfg_done_d  = cfg_done_q;
        iocs_d      = 1'b0;
        iorw_d      = 1'b1;
        ioaddr_d    = ADDR_DATA;
        dout_d      = dout_q;
        tx_ack_d    = 1'b0;
        rx_valid_d  = 1'b0;
        rx_data_d   = rx_data_q;
        echo_full_d = echo_full_q;
        echo_byte_d = echo_byte_q;
        src_echo_d  = src_echo_q;

        if (rd_done) begin
            rx_valid_d = 1'b1;
            rx_data_d  = databus;
            if (ECHO_EN) begin
                echo_full_d = 1'b1;
                echo_byte_d = databus;
            end
        end

        case (state_q)
            CFG_LO: begin
                cfg_sel_d  = br_sync_q;
                cfg_done_d = 1'b0;
                iocs_d     = 1'b1;
                iorw_d     = 1'b0;
                ioaddr_d   = ADDR_DIV_LO;
                dout_d     = DATA_W'(div_for(br_sync_q));
                state_d    = CFG_HI;
            end
            CFG_HI: begin
                iocs_d   = 1'b1;
                iorw_d   = 1'b0;
                ioaddr_d = ADDR_DIV_HI;
                dout_d   = DATA_W'(div_for(cfg_sel_q) >> DATA_W);
                state_d  = IDLE;
            end
            IDLE: begin
                if (br_sync_q != cfg_sel_q) begin
                    cfg_done_d = 1'b0;
                    state_d    = CFG_LO;
                end else begin
                    cfg_done_d = 1'b1;
                    // The echo buffer holds one byte: leave rda pending in
                    // the SPART until the previous byte has gone out.
                    if (rda && !echo_full_q) begin
                        state_d = RX_RD;
                    end else if (echo_full_q) begin
                        src_echo_d = 1'b1;
                        state_d    = TX_WAIT;
                    end else if (tx_req) begin
                        src_echo_d = 1'b0;
                        state_d    = TX_WAIT;
                    end
                end
            end
            RX_RD: begin
                iocs_d   = 1'b1;
                iorw_d   = 1'b1;
                ioaddr_d = ADDR_DATA;
                state_d  = GAP;
            end
            TX_WAIT: begin
                if (tbr) begin
                    state_d = TX_WR;
                end
            end
            TX_WR: begin
                iocs_d   = 1'b1;
                iorw_d   = 1'b0;
                ioaddr_d = ADDR_DATA;
                if (src_echo_q) begin
                    dout_d      = echo_byte_q;
                    echo_full_d = 1'b0;
                end else begin
                    dout_d   = tx_data;
                    tx_ack_d = 1'b1;
                end
                state_d = GAP;
            end
            GAP: begin
                // Lets rda/tbr settle after the access before re-deciding.
                state_d = IDLE;
            end
            default: begin
                state_d = CFG_LO;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= CFG_LO;
            cfg_sel_q   <= 2'b00;
            cfg_done_q  <= 1'b0;
            iocs_q      <= 1'b0;
            iorw_q      <= 1'b1;
            ioaddr_q    <= ADDR_DATA;
            dout_q      <= '0;
            tx_ack_q    <= 1'b0;
            rx_valid_q  <= 1'b0;
            rx_data_q   <= '0;
            echo_full_q <= 1'b0;
            echo_byte_q <= '0;
            src_echo_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cfg_sel_q   <= cfg_sel_d;
            cfg_done_q  <= cfg_done_d;
            iocs_q      <= iocs_d;
            iorw_q      <= iorw_d;
            ioaddr_q    <= ioaddr_d;
            dout_q      <= dout_d;
            tx_ack_q    <= tx_ack_d;
            rx_valid_q  <= rx_valid_d;
            rx_data_q   <= rx_data_d;
            echo_full_q <= echo_full_d;
            echo_byte_q <= echo_byte_d;
            src_echo_q  <= src_echo_d;
        end
    end

    // Drive the bus only on write strobes; the SPART owns it on reads.
    assign databus  = (iocs_q && !iorw_q) ? dout_q : 8'hzz;

    assign iocs     = iocs_q;
    assign iorw     = iorw_q;
    assign ioaddr   = ioaddr_q;
    assign tx_ack   = tx_ack_q;
    assign rx_valid = rx_valid_q;
    assign rx_data  = rx_data_q;
    assign cfg_done = cfg_done_q;

endmodule
